// File: rtl/ram_lsu_bridge.sv
// Single-outstanding LSU front end for the data RAM: turns byte/half/word requests into
// RAM strobes and word addresses, and returns lane-extracted, extended load data.
module ram_lsu_bridge #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    RAM_ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
    output logic [3:0]            ram_wr_en_o,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wr_data_o,
    output logic                  ram_rd_en_o,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_rd_data_i
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        RESP    = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  req_err;
    logic [3:0]            strobe;
    logic [DATA_WIDTH-1:0] lane_wdata;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [DATA_WIDTH-1:0] load_data;

    // NOTE: every always_comb assigns a default first so no path can infer a latch.
    always_comb begin
        req_err = 1'b0;
        case (req_size_i)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_addr_i[0];
            2'b10:   req_err = |req_addr_i[1:0];
            default: req_err = 1'b1;
        endcase
        if (req_addr_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH] != BASE_ADDR[ADDR_WIDTH-1:RAM_ADDR_WIDTH])
            req_err = 1'b1;
    end

    always_comb begin
        strobe     = 4'b1111;
        lane_wdata = wdata_q;
        case (size_q)
            2'b00: begin
                strobe     = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                strobe     = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_byte   = ram_rd_data_i[7:0];
        rd_half   = addr_q[1] ? ram_rd_data_i[31:16] : ram_rd_data_i[15:0];
        load_data = ram_rd_data_i;
        case (addr_q[1:0])
            2'b01:   rd_byte = ram_rd_data_i[15:8];
            2'b10:   rd_byte = ram_rd_data_i[23:16];
            2'b11:   rd_byte = ram_rd_data_i[31:24];
            default: rd_byte = ram_rd_data_i[7:0];
        endcase
        case (size_q)
            2'b00:   load_data = {{24{~uns_q & rd_byte[7]}}, rd_byte};
            2'b01:   load_data = {{16{~uns_q & rd_half[15]}}, rd_half};
            default: load_data = ram_rd_data_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    size_d  = req_size_i;
                    uns_d   = req_unsigned_i;
                    wdata_d = req_wdata_i;
                    err_d   = req_err;
                    rdata_d = '0;
                    if (req_err)       state_d = RESP;
                    else if (req_we_i) state_d = WRITE;
                    else               state_d = RD_ADDR;
                end
            end
            WRITE:   state_d = RESP;
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: begin
                rdata_d = load_data;
                state_d = RESP;
            end
            RESP:    if (resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ready_o   = (state_q == IDLE);
    assign resp_valid_o  = (state_q == RESP);
    assign resp_rdata_o  = rdata_q;
    assign resp_err_o    = err_q;
    assign ram_wr_en_o   = (state_q == WRITE) ? strobe : 4'b0000;
    assign ram_wr_addr_o = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign ram_wr_data_o = lane_wdata;
    assign ram_rd_en_o   = (state_q == RD_ADDR);
    assign ram_rd_addr_o = {addr_q[ADDR_WIDTH-1:2], 2'b00};

endmodule

// File: tb/tb_ram_lsu_bridge.sv
// Bench for ram_lsu_bridge: a word RAM behind the bridge plus a byte-level reference memory
// that predicts strobes, lane data, latency, errors and extended load results.
module tb_ram_lsu_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [1:0]  req_size_i = 2'b00;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_wdata_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic [3:0]  ram_wr_en_o;
    logic [31:0] ram_wr_addr_o;
    logic [31:0] ram_wr_data_o;
    logic        ram_rd_en_o;
    logic [31:0] ram_rd_addr_o;
    logic [31:0] ram_rd_data_i = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ram     [1024];
    logic [7:0]  ref_mem [4096];

    ram_lsu_bridge dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_addr_i     (req_addr_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_wdata_i    (req_wdata_i),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .resp_rdata_o   (resp_rdata_o),
        .resp_err_o     (resp_err_o),
        .ram_wr_en_o    (ram_wr_en_o),
        .ram_wr_addr_o  (ram_wr_addr_o),
        .ram_wr_data_o  (ram_wr_data_o),
        .ram_rd_en_o    (ram_rd_en_o),
        .ram_rd_addr_o  (ram_rd_addr_o),
        .ram_rd_data_i  (ram_rd_data_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_wr_en_o[i]) ram[ram_wr_addr_o[11:2]][8*i +: 8] <= ram_wr_data_o[8*i +: 8];
        if (ram_rd_en_o) ram_rd_data_i <= ram[ram_rd_addr_o[11:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int nb, input logic uns);
        longint v;
        v = 0;
        for (int k = 0; k < nb; k++) v = v | (longint'(ref_mem[a + k]) << (8 * k));
        if (!uns && v[8*nb-1]) v = v - (64'sd1 << (8 * nb));
        return v[31:0];
    endfunction

    task automatic wait_ready();
        int to;
        to = 0;
        @(negedge clk);
        while (!req_ready_o && to < 20) begin
            @(negedge clk);
            to++;
        end
        check("req_ready_wait", req_ready_o, 1);
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_addr_i     = addr;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_wdata_i    = wdata;
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, input int stall,
                       input bit early, output logic [31:0] rdata_out);
        int          nb, lat, wr_cnt, rd_cnt, exp_lat;
        bit          exp_err;
        logic [3:0]  strb_seen, exp_strb;
        logic [31:0] waddr_seen, wdata_seen, raddr_seen, exp_wdata, exp_rdata, r0;
        logic        e0;
        nb      = (size == 2'b11) ? 0 : (1 << size);
        exp_err = (size == 2'b11) || (addr >= 32'h1000) || (nb > 0 && (addr % nb) != 0);
        exp_lat = exp_err ? 1 : (we ? 2 : 3);
        exp_rdata = (we || exp_err) ? 32'h0 : ref_load(addr, nb, uns);
        exp_strb  = exp_err ? 4'h0 : 4'(((1 << nb) - 1) << (addr % 4));
        exp_wdata = '0;
        for (int lane = 0; lane < 4; lane++)
            if (nb > 0) exp_wdata[8*lane +: 8] = wdata[8*(lane % nb) +: 8];
        strb_seen = '0; waddr_seen = '0; wdata_seen = '0; raddr_seen = '0;
        lat = 0; wr_cnt = 0; rd_cnt = 0;

        wait_ready();
        drive(we, addr, size, uns, wdata);
        @(posedge clk);
        #1;
        req_valid_i  = 1'b0;
        resp_ready_i = early;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (ram_wr_en_o != 4'h0) begin
                wr_cnt++;
                strb_seen  = ram_wr_en_o;
                waddr_seen = ram_wr_addr_o;
                wdata_seen = ram_wr_data_o;
            end
            if (ram_rd_en_o) begin
                rd_cnt++;
                raddr_seen = ram_rd_addr_o;
            end
            if (resp_valid_o) lat = c;
        end
        check("latency", lat, exp_lat);
        check("resp_err", resp_err_o, exp_err);
        check("resp_rdata", resp_rdata_o, exp_rdata);
        check("wr_cycles", wr_cnt, (we && !exp_err) ? 1 : 0);
        check("rd_cycles", rd_cnt, (!we && !exp_err) ? 1 : 0);
        if (we && !exp_err) begin
            check("wr_strobe", strb_seen, exp_strb);
            check("wr_addr", waddr_seen, addr & ~32'h3);
            check("wr_data", wdata_seen, exp_wdata);
            for (int k = 0; k < nb; k++) ref_mem[addr + k] = wdata[8*k +: 8];
        end
        if (!we && !exp_err) check("rd_addr", raddr_seen, addr & ~32'h3);

        r0 = resp_rdata_o;
        e0 = resp_err_o;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", resp_valid_o, 1);
            check("stall_rdata", resp_rdata_o, r0);
            check("stall_err", resp_err_o, e0);
            check("stall_req_ready", req_ready_o, 0);
        end
        resp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        resp_ready_i = 1'b0;
        @(negedge clk);
        check("resp_cleared", resp_valid_o, 0);
        check("ready_after_resp", req_ready_o, 1);
        rdata_out = r0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  sz;
        logic [31:0] a;
        int          stall;
        for (int i = 0; i < 1024; i++) ram[i] = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = '0;

        #12;
        check("rst_req_ready", req_ready_o, 1);
        check("rst_resp_valid", resp_valid_o, 0);
        check("rst_wr_en", ram_wr_en_o, 0);
        check("rst_rd_en", ram_rd_en_o, 0);
        check("rst_rdata", resp_rdata_o, 0);
        check("rst_wr_addr", ram_wr_addr_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        txn(1'b1, 32'h100, 2'b10, 1'b0, 32'hDEADBEEF, 0, 1'b0, rd);
        txn(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 0, 1'b0, rd);
        check("t1_lw", rd, 32'hDEADBEEF);

        txn(1'b1, 32'h103, 2'b00, 1'b0, 32'h00000080, 0, 1'b0, rd);
        txn(1'b0, 32'h103, 2'b00, 1'b0, 32'h0, 0, 1'b0, rd);
        check("t2_lb", rd, 32'hFFFFFF80);
        txn(1'b0, 32'h103, 2'b00, 1'b1, 32'h0, 0, 1'b0, rd);
        check("t2_lbu", rd, 32'h00000080);

        txn(1'b1, 32'h102, 2'b01, 1'b0, 32'h00008001, 0, 1'b0, rd);
        txn(1'b0, 32'h102, 2'b01, 1'b0, 32'h0, 0, 1'b0, rd);
        check("t3_lh", rd, 32'hFFFF8001);
        txn(1'b0, 32'h102, 2'b01, 1'b1, 32'h0, 0, 1'b0, rd);
        check("t3_lhu", rd, 32'h00008001);

        txn(1'b0, 32'h101, 2'b10, 1'b0, 32'h0, 0, 1'b0, rd);
        txn(1'b1, 32'h103, 2'b01, 1'b0, 32'h1234, 0, 1'b0, rd);
        txn(1'b0, 32'h100, 2'b11, 1'b0, 32'h0, 0, 1'b0, rd);
        txn(1'b0, 32'h1000, 2'b10, 1'b0, 32'h0, 0, 1'b0, rd);

        txn(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 5, 1'b0, rd);
        check("t5_lw", rd, 32'h8001BEEF);
        txn(1'b0, 32'h102, 2'b01, 1'b1, 32'h0, 0, 1'b1, rd);
        check("early_ready_lhu", rd, 32'h00008001);

        wait_ready();
        drive(1'b1, 32'h200, 2'b10, 1'b0, 32'h55AA55AA);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        check("t6_pending_strobe", ram_wr_en_o, 4'hF);
        rst_n = 1'b0;
        #1;
        check("t6w_wr_en", ram_wr_en_o, 0);
        check("t6w_resp_valid", resp_valid_o, 0);
        check("t6w_req_ready", req_ready_o, 1);
        check("t6w_wr_addr", ram_wr_addr_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        wait_ready();
        drive(1'b0, 32'h100, 2'b10, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6r_rd_en", ram_rd_en_o, 0);
        check("t6r_resp_valid", resp_valid_o, 0);
        check("t6r_rdata", resp_rdata_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t6_no_resp", resp_valid_o, 0);
        end
        txn(1'b1, 32'h100, 2'b10, 1'b0, 32'hDEADBEEF, 0, 1'b0, rd);
        txn(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 0, 1'b0, rd);
        check("t6_lw", rd, 32'hDEADBEEF);
        txn(1'b0, 32'h200, 2'b10, 1'b0, 32'h0, 0, 1'b0, rd);
        check("t6_dropped_store", rd, 32'h0);

        for (int n = 0; n < 200; n++) begin
            sz    = 2'($urandom_range(0, 3));
            a     = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 4095);
            if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'h1 << sz) - 1);
            stall = $urandom_range(0, 2);
            txn(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom,
                stall, (stall == 0) && ($urandom_range(0, 1) == 1), rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
